// File: rtl/id_operand_issue.sv
// id_operand_issue: drives the register-file reads, tracks in-flight destinations in a busy
// scoreboard, bypasses writeback data and captures operands into the ID/EX register.
module id_operand_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic        in_use_rs,
    input  logic        in_use_rt,
    input  logic [4:0]  in_rd,
    input  logic        in_wr,
    output logic        rf_re_1,
    output logic        rf_re_2,
    output logic [4:0]  rf_addr_1,
    output logic [4:0]  rf_addr_2,
    input  logic [31:0] rf_data_1,
    input  logic [31:0] rf_data_2,
    input  logic        wb_we,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_op_a,
    output logic [31:0] out_op_b,
    output logic [4:0]  out_rd,
    output logic        out_wr,
    output logic [31:0] stall_cnt
);
    logic [31:0] busy, busy_nxt, op_a, op_b;
    logic        clr_rs, clr_rt, hazard, accept;

    // a writeback landing this cycle releases a RAW hazard but not a WAW one
    assign clr_rs    = wb_we && wb_reg == in_rs && in_rs != 5'd0;
    assign clr_rt    = wb_we && wb_reg == in_rt && in_rt != 5'd0;
    assign hazard    = (in_use_rs && busy[in_rs] && !clr_rs) ||
                       (in_use_rt && busy[in_rt] && !clr_rt) ||
                       (in_wr && busy[in_rd]);
    assign in_ready  = !rst && !flush && !hazard && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign rf_re_1   = in_valid && in_use_rs;
    assign rf_re_2   = in_valid && in_use_rt;
    assign rf_addr_1 = in_rs;
    assign rf_addr_2 = in_rt;
    assign op_a      = (!in_use_rs || in_rs == 5'd0) ? 32'd0 : (wb_we && wb_reg == in_rs) ? wb_data : rf_data_1;
    assign op_b      = (!in_use_rt || in_rt == 5'd0) ? 32'd0 : (wb_we && wb_reg == in_rt) ? wb_data : rf_data_2;

    // set is applied after the clears so a same-cycle set wins
    always_comb begin
        busy_nxt = busy;
        if (wb_we) busy_nxt[wb_reg] = 1'b0;
        if (flush && out_valid && out_wr) busy_nxt[out_rd] = 1'b0;
        if (accept && in_wr) busy_nxt[in_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 32'd0;
            stall_cnt <= 32'd0;
            out_valid <= 1'b0;
            out_op_a  <= 32'd0;
            out_op_b  <= 32'd0;
            out_rd    <= 5'd0;
            out_wr    <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (in_valid && !in_ready) stall_cnt <= stall_cnt + 32'd1;
            if (accept) begin
                out_valid <= 1'b1;
                out_op_a  <= op_a;
                out_op_b  <= op_b;
                out_rd    <= in_rd;
                out_wr    <= in_wr;
            end else if (flush || out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_id_operand_issue.sv
// tb_id_operand_issue: random issue traffic against a pending-instruction model; a monitor
// checks each consumed ID/EX entry against a scoreboard queue.
module tb_id_operand_issue;
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_use_rs, in_use_rt, in_wr;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic        rf_re_1, rf_re_2;
    logic [4:0]  rf_addr_1, rf_addr_2;
    logic [31:0] rf_data_1, rf_data_2;
    logic        wb_we;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        flush, out_valid, out_ready, out_wr;
    logic [31:0] out_op_a, out_op_b, stall_cnt;
    logic [4:0]  out_rd;

    logic [31:0] rf [32];
    exp_t        sb [$];
    logic [4:0]  ifq [$];
    bit          mv, h_wr;
    logic [4:0]  h_rd;
    logic [31:0] exp_stall;
    bit          pw_we;
    logic [4:0]  pw_reg;
    logic [31:0] pw_data;
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign rf_data_1 = rf[rf_addr_1];
    assign rf_data_2 = rf[rf_addr_2];

    id_operand_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
        .in_rd(in_rd), .in_wr(in_wr), .rf_re_1(rf_re_1), .rf_re_2(rf_re_2),
        .rf_addr_1(rf_addr_1), .rf_addr_2(rf_addr_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
        .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_op_a(out_op_a), .out_op_b(out_op_b),
        .out_rd(out_rd), .out_wr(out_wr), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // a register is pending while some accepted, unsquashed instruction still owes its writeback
    function automatic bit pend(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        if (mv && h_wr && h_rd == r) return 1'b1;
        foreach (ifq[i]) if (ifq[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] sel(input logic use_it, input logic [4:0] s);
        if (!use_it || s == 5'd0) return 32'd0;
        return (wb_we && wb_reg == s) ? wb_data : rf[s];
    endfunction

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #4;
            if (!rst && out_valid && out_ready && !flush) begin
                if (sb.size() == 0) begin
                    chk("mon_unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("op_a", out_op_a, e.a);
                    chk("op_b", out_op_b, e.b);
                    chk("rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("wr", {31'd0, out_wr}, {31'd0, e.wr});
                end
            end
        end
    end

    initial begin
        int  wi;
        bit  haz, rdy, acc;
        logic [4:0] r;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rst = 1'b1; in_valid = 1'b0; in_rs = 0; in_rt = 0; in_use_rs = 0; in_use_rt = 0;
        in_rd = 0; in_wr = 0; wb_we = 0; wb_reg = 0; wb_data = 0; flush = 0; out_ready = 0;
        mv = 0; h_wr = 0; h_rd = 0; exp_stall = 0; pw_we = 0; pw_reg = 0; pw_data = 0;
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_op_a", out_op_a, 32'd0);
        chk("rst_op_b", out_op_b, 32'd0);
        chk("rst_rd_wr", {26'd0, out_rd, out_wr}, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (pw_we) rf[pw_reg] = pw_data;
            pw_we = 0;
            rst       = (cyc >= 2000 && cyc < 2002);
            in_valid  = $urandom_range(0, 3) != 0;
            in_rs     = 5'($urandom_range(0, 7));
            in_rt     = 5'($urandom_range(0, 7));
            in_use_rs = $urandom_range(0, 3) != 0;
            in_use_rt = $urandom_range(0, 3) != 0;
            in_rd     = 5'($urandom_range(0, 7));
            in_wr     = 1'($urandom_range(0, 1));
            flush     = !rst && $urandom_range(0, 19) == 0;
            out_ready = !rst && !flush &&
                        (((cyc / 60) % 3 == 2) ? $urandom_range(0, 3) == 0 : $urandom_range(0, 9) < 8);
            wb_we = 0; wb_reg = 0; wb_data = $urandom; wi = -1;
            if (!rst && ifq.size() > 0 && $urandom_range(0, 9) < 4) begin
                wi = $urandom_range(0, ifq.size() - 1);
                wb_we = 1; wb_reg = ifq[wi];
            end else if (!rst && $urandom_range(0, 7) == 0) begin
                r = 5'($urandom_range(0, 7));
                if (!pend(r)) begin wb_we = 1; wb_reg = r; end
            end
            #1;
            if (rst) begin
                chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
                mv = 0; ifq.delete(); sb.delete(); exp_stall = 0;
                continue;
            end
            chk("stall_cnt", stall_cnt, exp_stall);
            chk("out_valid", {31'd0, out_valid}, {31'd0, mv});
            chk("rf_re", {30'd0, rf_re_1, rf_re_2}, {30'd0, in_valid && in_use_rs, in_valid && in_use_rt});
            haz = (in_use_rs && pend(in_rs) && !(wb_we && wb_reg == in_rs)) ||
                  (in_use_rt && pend(in_rt) && !(wb_we && wb_reg == in_rt)) ||
                  (in_wr && pend(in_rd));
            rdy = !flush && !haz && (!mv || out_ready);
            chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
            acc = in_valid && rdy;
            if (in_valid && !rdy) exp_stall++;
            if (acc) sb.push_back('{sel(in_use_rs, in_rs), sel(in_use_rt, in_rt), in_rd, in_wr});
            if (wi >= 0) ifq.delete(wi);
            if (wb_we) begin pw_we = 1; pw_reg = wb_reg; pw_data = wb_data; end
            if (flush) begin
                if (mv) void'(sb.pop_front());
                mv = 0;
            end else begin
                if (mv && out_ready) begin
                    if (h_wr && h_rd != 5'd0) ifq.push_back(h_rd);
                    mv = 0;
                end
                if (acc) begin mv = 1; h_rd = in_rd; h_wr = in_wr; end
            end
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/id_operand_issue.md
# id_operand_issue

Decode-side register-read and issue unit: drives the register file's two read ports and captures the operands into the ID/EX register. It keeps a per-register busy scoreboard so RAW and WAW hazards stall issue until the producer writes back. It observes the same write-port signals the writeback stage drives into the register file, and bypasses writeback data itself instead of relying on the register file's internal forwarding. It sits between instruction decode and the execute stage.

## Interface
- No parameters; widths are fixed (32-bit data, 5-bit register index).
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded instruction present
- in_ready  out  1  instruction accepted this cycle when in_valid && in_ready
- in_rs, in_rt  in  5  source register indices
- in_use_rs, in_use_rt  in  1  source actually read
- in_rd  in  5  destination index
- in_wr  in  1  instruction writes in_rd
- rf_re_1, rf_re_2  out  1  register-file read enables (= in_valid && in_use_rs / in_use_rt)
- rf_addr_1, rf_addr_2  out  5  register-file read addresses (= in_rs / in_rt)
- rf_data_1, rf_data_2  in  32  register-file read data (combinational)
- wb_we  in  1  writeback write enable (same net as the regfile write_enable)
- wb_reg  in  5  writeback index
- wb_data  in  32  writeback data
- flush  in  1  squash the unissued ID/EX contents
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute stage consumes the instruction
- out_op_a, out_op_b  out  32  captured operands
- out_rd  out  5  captured destination
- out_wr  out  1  captured write flag
- stall_cnt  out  32  count of cycles with in_valid && !in_ready

## Operation
- Scoreboard busy[31:1]. busy[0] is constant 0.
- hazard = (in_use_rs && busy[in_rs] && !clr_rs) || (in_use_rt && busy[in_rt] && !clr_rt) || (in_wr && busy[in_rd]).
  - clr_x means wb_we && wb_reg == x && x != 0 in the same cycle (same-cycle writeback releases the RAW hazard).
  - The WAW term is not relaxed by same-cycle writeback.
- in_ready = !rst && !flush && !hazard && (!out_valid || out_ready).
- Operand select, for a and likewise b:
  - If the source is unused or is index 0: 0.
  - Otherwise, if wb_we && wb_reg == source: wb_data.
  - Otherwise: rf_data.
- On accept:
  - out_op_a/b, out_rd, out_wr load; out_valid <= 1.
  - If in_wr && in_rd != 0, set busy[in_rd].
- If out_valid && out_ready && no accept: out_valid <= 0. Payload registers hold their value.
- Busy clear: wb_we && wb_reg != 0 clears busy[wb_reg]. A set and a clear of the same index in the same cycle leave the bit set.
- flush:
  - out_valid <= 0.
  - If the squashed entry had out_wr && out_rd != 0, clear busy[out_rd].
  - No accept that cycle.
  - Instructions already passed to execute are unaffected and clear their bits at writeback.
- stall_cnt increments by 1 per stalled cycle, wraps 0xFFFFFFFF -> 0, and is not cleared by flush.

## Timing
- Reset (rst high at an edge): out_valid = 0, out_op_a = out_op_b = 0, out_rd = 0, out_wr = 0, busy = 0, stall_cnt = 0. in_ready = 0 while rst is high.
- Latency:
  - Accept at edge N -> out_valid = 1 after edge N.
  - Throughput is 1 per cycle when there are no hazards and out_ready = 1.
- Register-file reads are combinational in the accept cycle. The bypass covers a writeback landing in the same cycle.
- A dependent instruction waiting on a writeback in cycle W is accepted in cycle W (bypass), not W+1.
- Back-pressure: while out_valid && !out_ready, outputs are held stable and in_ready = 0.
- Reset mid-operation discards the pending scoreboard. The environment must also reset downstream stages.

## Test plan
- Reset, then accept rs=3 and rt=4 with r3=0x11 and r4=0x22 in the regfile -> out_op_a=0x11, out_op_b=0x22 one edge later, stall_cnt=0.
- Issue a write to r5, then a reader of r5. Hold wb idle 3 cycles, then wb_we with wb_reg=5 and wb_data=0xDEAD -> reader stalls 3 cycles, is accepted in the wb cycle with out_op_a=0xDEAD, stall_cnt=3.
- Issue a write to r7, then another write to r7 (WAW) -> second stalls until the cycle after r7's writeback. A same-cycle set and clear of r7 leaves busy[7]=1.
- Reader of r0 with in_rd=0, in_wr=1 -> operand 0, no busy bit set, never stalls.
- out_ready=0 for 4 cycles with valid input -> out_* stable, in_ready=0, stall_cnt+=4. Releasing out_ready resumes one instruction per cycle.
- out_valid entry writing r9, then flush -> out_valid=0 next edge, busy[9]=0, and a following reader of r9 is accepted without a stall.
